// File: rtl/proc_pkg.sv
// Shared branch-unit definitions: branch kinds, compare-flag codes, FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package proc_pkg;

  // Branch kinds carried on br_type
  localparam logic [2:0] BR_BEQ = 3'b000;
  localparam logic [2:0] BR_BNE = 3'b001;
  localparam logic [2:0] BR_BLT = 3'b010;
  localparam logic [2:0] BR_BGE = 3'b011;
  localparam logic [2:0] BR_BGT = 3'b100;
  localparam logic [2:0] BR_BLE = 3'b101;
  localparam logic [2:0] BR_JMP = 3'b110;
  localparam logic [2:0] BR_RSV = 3'b111;

  // Compare-unit result codes on {c1,c0}
  localparam logic [1:0] CMP_EQ  = 2'b11;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_LT  = 2'b01;
  localparam logic [1:0] CMP_INV = 2'b00;

  // Sequential fetch increment
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: maps branch kind and compare flags to taken/error.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to use it.
module branch_cond
  import proc_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic [1:0] flags,
  output logic       cond_true,
  output logic       cond_err
);

  logic is_eq;
  logic is_gt;
  logic is_lt;
  logic is_inv;

  assign is_eq  = (flags == CMP_EQ);
  assign is_gt  = (flags == CMP_GT);
  assign is_lt  = (flags == CMP_LT);
  assign is_inv = (flags == CMP_INV);

  // Decode table; invalid flags only matter for the flag-driven kinds
  always_comb begin
    cond_true = 1'b0;
    cond_err  = 1'b0;
    case (br_type)
      BR_BEQ: cond_true = is_eq;
      BR_BNE: cond_true = is_gt | is_lt;
      BR_BLT: cond_true = is_lt;
      BR_BGE: cond_true = is_eq | is_gt;
      BR_BGT: cond_true = is_gt;
      BR_BLE: cond_true = is_eq | is_lt;
      BR_JMP: cond_true = 1'b1;
      default: cond_err = 1'b1;
    endcase
    if (is_inv && (br_type != BR_JMP) && (br_type != BR_RSV)) begin
      cond_err = 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution and fetch-PC owner: redirects PC on taken branches, then flushes.
// Latency: one cycle from br_valid to pc/taken/flush; flush lasts FLUSH_CYCLES unstalled cycles.
// Backpressure: stall freezes PC, FSM and counters; a stalled branch is not evaluated and must be held.
module branch_resolve
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic             c1,
  input  logic             c0,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic             taken,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             err
);

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  br_state_t        state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             err_q, err_d;

  logic cond_true;
  logic cond_err;
  logic misaligned;
  logic br_go;

  branch_cond u_cond (
    .br_type   (br_type),
    .flags     ({c1, c0}),
    .cond_true (cond_true),
    .cond_err  (cond_err)
  );

  // A taken branch to a non-word target is refused and reported instead
  assign misaligned = (br_target[1:0] != 2'b00);
  assign br_go      = cond_true & ~misaligned;

  // State, PC and debug registers; reset abandons any flush in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= 4'd0;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: hold everything by default, taken never stretches
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (br_valid && br_go) begin
            pc_d    = br_target;
            taken_d = 1'b1;
            fcnt_d  = FLUSH_LOAD;
            state_d = ST_FLUSH;
            if (tcnt_q != CNT_MAX) begin
              tcnt_d = tcnt_q + CNT_ONE;
            end
          end else begin
            pc_d = pc_q + PC_STEP;
          end
          if (br_valid && (cond_err || (cond_true && misaligned))) begin
            err_d = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_d = pc_q + PC_STEP;
          if (fcnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  // Flush and busy both mirror the registered FSM state
  assign flush     = (state_q == ST_FLUSH);
  assign busy      = (state_q == ST_FLUSH);
  assign pc        = pc_q;
  assign taken     = taken_q;
  assign taken_cnt = tcnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: reference model plus directed vectors.
// Latency: checks every cycle on the falling edge.
// Backpressure: exercises stall in RUN and FLUSH.
module tb_branch_resolve;

  localparam int FC = 2;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          br_valid;
  logic [2:0]    br_type;
  logic          c1;
  logic          c0;
  logic [31:0]   br_target;
  logic [31:0]   pc;
  logic          taken;
  logic          flush;
  logic          busy;
  logic [CW-1:0] taken_cnt;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  branch_resolve #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_type   (br_type),
    .c1        (c1),
    .c0        (c0),
    .br_target (br_target),
    .pc        (pc),
    .taken     (taken),
    .flush     (flush),
    .busy      (busy),
    .taken_cnt (taken_cnt),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] m_pc;
  int          m_left;
  bit          m_taken;
  int          m_cnt;
  bit          m_err;
  bit          m_go;
  bit          m_e;

  // Which flag codes (indexed by {c1,c0}) make each branch kind taken
  function automatic bit model_decide(input logic [2:0] t, input logic [1:0] f,
                                      input logic [31:0] tgt, output bit e);
    bit [3:0] allowed;
    bit       go;
    case (t)
      3'd0:    allowed = 4'b1000;
      3'd1:    allowed = 4'b0110;
      3'd2:    allowed = 4'b0010;
      3'd3:    allowed = 4'b1100;
      3'd4:    allowed = 4'b0100;
      3'd5:    allowed = 4'b1010;
      3'd6:    allowed = 4'b1111;
      default: allowed = 4'b0000;
    endcase
    go = allowed[f];
    e  = (t == 3'd7) || (t < 3'd6 && f == 2'b00);
    if (go && tgt[1:0] != 2'b00) begin
      go = 1'b0;
      e  = 1'b1;
    end
    return go;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_left = 0; m_taken = 0; m_cnt = 0; m_err = 0;
    end else if (stall) begin
      m_taken = 0;
    end else if (m_left > 0) begin
      m_pc = m_pc + 32'd4; m_left = m_left - 1; m_taken = 0;
    end else begin
      m_go = model_decide(br_type, {c1, c0}, br_target, m_e);
      if (!br_valid) begin m_go = 0; m_e = 0; end
      if (m_go) begin
        m_pc = br_target; m_taken = 1; m_left = FC;
        if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      end else begin
        m_pc = m_pc + 32'd4; m_taken = 0;
      end
      if (m_e) m_err = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("taken", {31'd0, taken}, {31'd0, m_taken});
    check("flush", {31'd0, flush}, {31'd0, m_left > 0});
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    check("err", {31'd0, err}, {31'd0, m_err});
  end

  task automatic tick(input bit v, input logic [2:0] t, input logic [1:0] f,
                      input logic [31:0] tg, input bit st);
    br_valid = v; br_type = t; {c1, c0} = f; br_target = tg; stall = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 3'd0, 2'b11, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_type = 3'd0;
    c1 = 1'b0; c0 = 1'b0; br_target = 32'h0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("lit_reset_pc", pc, 32'h0);
    check("lit_reset_flush", {31'd0, flush}, 32'd0);
    check("lit_reset_err", {31'd0, err}, 32'd0);

    idle(); check("lit_pc4", pc, 32'h4);
    idle(); check("lit_pc8", pc, 32'h8);
    idle(); check("lit_pcC", pc, 32'hC);
    idle(); check("lit_pc10", pc, 32'h10);

    // BEQ equal -> taken to 0x100, two flush cycles
    tick(1'b1, 3'd0, 2'b11, 32'h100, 1'b0);
    check("lit_beq_pc", pc, 32'h100);
    check("lit_beq_taken", {31'd0, taken}, 32'd1);
    check("lit_beq_cnt", 32'(taken_cnt), 32'd1);
    idle(); check("lit_fl1_pc", pc, 32'h104);
    check("lit_fl1_flush", {31'd0, flush}, 32'd1);
    check("lit_fl1_taken", {31'd0, taken}, 32'd0);
    idle(); check("lit_fl2_pc", pc, 32'h108);
    check("lit_fl2_flush", {31'd0, flush}, 32'd0);

    // BLT with GT flags not taken, BGT with GT flags taken
    tick(1'b1, 3'd2, 2'b10, 32'h300, 1'b0);
    check("lit_blt_pc", pc, 32'h10C);
    tick(1'b1, 3'd4, 2'b10, 32'h300, 1'b0);
    check("lit_bgt_pc", pc, 32'h300);
    check("lit_bgt_cnt", 32'(taken_cnt), 32'd2);
    idle(); idle();

    // Misaligned JMP refused; JMP ignores invalid flags
    tick(1'b1, 3'd6, 2'b11, 32'h102, 1'b0);
    check("lit_misal_pc", pc, 32'h30C);
    check("lit_misal_err", {31'd0, err}, 32'd1);
    tick(1'b1, 3'd6, 2'b00, 32'h200, 1'b0);
    check("lit_jmp_pc", pc, 32'h200);
    tick(1'b1, 3'd0, 2'b11, 32'h400, 1'b0);
    check("lit_ignored_pc", pc, 32'h204);
    idle();

    // Stall inside FLUSH freezes everything
    tick(1'b1, 3'd0, 2'b11, 32'h500, 1'b0);
    repeat (3) tick(1'b0, 3'd0, 2'b11, 32'h0, 1'b1);
    check("lit_stall_pc", pc, 32'h500);
    check("lit_stall_flush", {31'd0, flush}, 32'd1);
    check("lit_stall_taken", {31'd0, taken}, 32'd0);
    idle(); check("lit_unstall_pc", pc, 32'h504);
    idle(); check("lit_unstall_flush", {31'd0, flush}, 32'd0);

    // Stalled branch in RUN is not evaluated
    tick(1'b1, 3'd0, 2'b11, 32'h3000, 1'b1);
    idle();

    // Full decode sweep, then saturate the counter
    for (int t = 0; t < 6; t++) begin
      for (int f = 0; f < 4; f++) begin
        tick(1'b1, 3'(t), 2'(f), 32'h1000 + 32'((t * 4 + f) * 16), 1'b0);
        repeat (FC) idle();
      end
    end
    repeat (4) begin
      tick(1'b1, 3'd6, 2'b00, 32'h2000, 1'b0);
      repeat (FC) idle();
    end
    check("lit_sat_cnt", 32'(taken_cnt), 32'd15);
    check("lit_err_sticky", {31'd0, err}, 32'd1);

    // PC wrap at the top of the address space
    tick(1'b1, 3'd6, 2'b11, 32'hFFFF_FFF8, 1'b0);
    idle(); check("lit_wrap_top", pc, 32'hFFFF_FFFC);
    idle(); check("lit_wrap_zero", pc, 32'h0);

    // Reset in the middle of a flush
    tick(1'b1, 3'd6, 2'b11, 32'h700, 1'b0);
    check("lit_pre_rst_flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    #1;
    check("lit_rst_pc", pc, 32'h0);
    check("lit_rst_flush", {31'd0, flush}, 32'd0);
    check("lit_rst_busy", {31'd0, busy}, 32'd0);
    check("lit_rst_cnt", 32'(taken_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reserved type sets err
    tick(1'b1, 3'd7, 2'b11, 32'h40, 1'b0);
    check("lit_rsv_pc", pc, 32'h4);
    check("lit_rsv_err", {31'd0, err}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // Invalid flags on a conditional branch set err
    tick(1'b1, 3'd0, 2'b00, 32'h80, 1'b0);
    check("lit_inv_pc", pc, 32'h4);
    check("lit_inv_err", {31'd0, err}, 32'd1);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
